// File: rtl/prog_loader.sv
// prog_loader: bit-serial program loader writing a 2^N x 8 program RAM; holds the core until the load completes.
// Optional: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte. Revision 1.0.
`default_nettype none

module prog_loader #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load_req,
  input  logic         i_bit_in,
  input  logic         i_bit_valid,
  input  logic [N-1:0] i_rd_addr,
  output logic [7:0]   o_rd_data,
  output logic         o_core_en,
  output logic         o_busy,
  output logic         o_err
);

  localparam int WORD  = 8;
  localparam int DEPTH = 1 << N;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    S_CHK  = 3'd3,
    S_ERR  = 3'd4
`endif
  } state_t;

  state_t            r_state;
  logic [WORD-1:0]   r_mem [DEPTH];
  logic [WORD-2:0]   r_shift;
  logic [2:0]        r_cnt;
  logic [N-1:0]      r_wr_addr;
  logic              r_core_en;
  logic              r_busy;
  logic [WORD-1:0]   w_byte;
  logic              w_byte_done;
  logic              w_last_addr;

  assign w_byte      = {r_shift, i_bit_in};
  assign w_byte_done = i_bit_valid && (r_cnt == 3'd7);
  assign w_last_addr = (r_wr_addr == {N{1'b1}});
  assign o_rd_data   = r_mem[i_rd_addr];
  assign o_core_en   = r_core_en;
  assign o_busy      = r_busy;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [WORD-1:0] r_csum;
  logic            r_err;
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_core_en <= 1'b0;
      r_busy    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum    <= '0;
      r_err     <= 1'b0;
`endif
    end else if (i_load_req) begin
      // A restart wins over any bit arriving in the same cycle.
      r_state   <= S_LOAD;
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_core_en <= 1'b0;
      r_busy    <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum    <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_LOAD: begin
          if (i_bit_valid) begin
            r_shift <= w_byte[WORD-2:0];
            r_cnt   <= r_cnt + 3'd1;
          end
          if (w_byte_done) begin
            r_mem[r_wr_addr] <= w_byte;
            r_wr_addr        <= r_wr_addr + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ w_byte;
            if (w_last_addr) r_state <= S_CHK;
`else
            if (w_last_addr) begin
              r_state   <= S_RUN;
              r_core_en <= 1'b1;
              r_busy    <= 1'b0;
            end
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (i_bit_valid) begin
            r_shift <= w_byte[WORD-2:0];
            r_cnt   <= r_cnt + 3'd1;
          end
          if (w_byte_done) begin
            r_busy <= 1'b0;
            if (w_byte == r_csum) begin
              r_state   <= S_RUN;
              r_core_en <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// tb_prog_loader: vector-table and scoreboard bench for prog_loader (N=2).
`default_nettype none

module tb_prog_loader;

  localparam int N     = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         lr = 1'b0;
  logic         bv = 1'b0;
  logic         bi = 1'b0;
  logic [N-1:0] ra = '0;
  logic [7:0]   rd;
  logic         en, busy, err;

  always #5 clk = ~clk;

  prog_loader #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load_req (lr),
    .i_bit_in   (bi),
    .i_bit_valid(bv),
    .i_rd_addr  (ra),
    .o_rd_data  (rd),
    .o_core_en  (en),
    .o_busy     (busy),
    .o_err      (err)
  );

  typedef struct {
    logic lr;
    logic bv;
    logic bi;
    logic en;
    logic busy;
    logic err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic l, input logic v, input logic b,
                              input logic e, input logic bz, input logic er);
    vec_t t;
    t.lr = l; t.bv = v; t.bi = b; t.en = e; t.busy = bz; t.err = er;
    return t;
  endfunction

  // Builds the cycle table for one load; expectations are what the outputs must show after each edge.
  function automatic void add_load(input logic [31:0] w, input int gap,
                                   input logic with_req, input logic [7:0] cflip);
    logic [7:0] bytes[DEPTH+1];
    logic [7:0] x;
    int         nb;
    logic       good;
    logic       last;
    x = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      bytes[k] = w[31-8*k -: 8];
      x = x ^ bytes[k];
    end
    bytes[DEPTH] = x ^ cflip;
`ifdef PROG_LOADER_CHECKSUM_EN
    nb = DEPTH + 1;
`else
    nb = DEPTH;
`endif
    good = (cflip == 8'h00);
    if (with_req) vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < nb; k++) begin
      for (int i = 7; i >= 0; i--) begin
        for (int g = 0; g < gap; g++) vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        last = (k == nb - 1) && (i == 0);
        vecs.push_back(mk(1'b0, 1'b1, bytes[k][i], last && good, !last, last && !good));
      end
    end
  endfunction

  task automatic run_vecs(input int n);
    vec_t v;
    vec_t e;
    int   cnt;
    cnt = 0;
    while (vecs.size() > 0 && (n < 0 || cnt < n)) begin
      v  = vecs.pop_front();
      lr = v.lr; bv = v.bv; bi = v.bi;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("core_en", {7'd0, en},   {7'd0, e.en});
      chk("busy",    {7'd0, busy}, {7'd0, e.busy});
      chk("err",     {7'd0, err},  {7'd0, e.err});
      cnt++;
    end
    lr = 1'b0; bv = 1'b0; bi = 1'b0;
  endtask

  task automatic check_ram(input logic [31:0] w, input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      ra = a[N-1:0];
      #1;
      chk(tag, rd, w[31-8*a -: 8]);
    end
  endtask

  initial begin
    // Reset: everything cleared, core held.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_core_en", {7'd0, en},   8'd0);
    chk("rst_busy",    {7'd0, busy}, 8'd0);
    chk("rst_err",     {7'd0, err},  8'd0);
    check_ram(32'h00000000, "rst_ram");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Contiguous load.
    add_load(32'hA53C0FF0, 0, 1'b1, 8'h00);
    run_vecs(-1);
    check_ram(32'hA53C0FF0, "load_ram");

    // bit_valid in RUN is ignored.
    repeat (3) vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    run_vecs(-1);
    check_ram(32'hA53C0FF0, "run_ignore_ram");

    // Reload from RUN with a colliding bit; that bit must be dropped.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    add_load(32'h11223344, 0, 1'b0, 8'h00);
    run_vecs(9);
    check_ram(32'h113C0FF0, "partial_reload_ram");
    run_vecs(-1);
    check_ram(32'h11223344, "reload_ram");

    // Gapped load: one valid bit every third cycle.
    add_load(32'hA53C0FF0, 2, 1'b1, 8'h00);
    run_vecs(-1);
    check_ram(32'hA53C0FF0, "gapped_ram");

    // Reset in the middle of a load.
    add_load(32'hDEADBEEF, 0, 1'b1, 8'h00);
    run_vecs(13);
    check_ram(32'hDE3C0FF0, "pre_abort_ram");
    vecs.delete();
    rst_n = 1'b0;
    #1;
    chk("abort_core_en", {7'd0, en},   8'd0);
    chk("abort_busy",    {7'd0, busy}, 8'd0);
    check_ram(32'h00000000, "abort_ram");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    run_vecs(-1);
    check_ram(32'h00000000, "idle_ignore_ram");

`ifdef PROG_LOADER_CHECKSUM_EN
    add_load(32'hA53C0FF0, 0, 1'b1, 8'h00);
    run_vecs(-1);
    check_ram(32'hA53C0FF0, "csum_ok_ram");
    add_load(32'hA53C0FF0, 0, 1'b1, 8'h01);
    run_vecs(-1);
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    run_vecs(-1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
